bmi_rot_issue: RTL and testbench
================================

BMI_ROT_ISSUE -- requirements
Module: bmi_rot_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 256, operand and result width in bits.
REQ-002 Parameter ROT_LATENCY, default 1, clock edges from rotator input to valid rotator output; legal range 0..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_op  input  1  0 = rotate right, 1 = rotate left.
REQ-008 in_a  input  DATA_WIDTH  operand to rotate.
REQ-009 in_shamt  input  8  rotate amount, 0..255.
REQ-010 rot_enable  output  1  drives the rotator enable.
REQ-011 rot_a  output  DATA_WIDTH  operand to the rotator.
REQ-012 rot_shift  output  DATA_WIDTH  right-rotate amount to the rotator, in bits [7:0]; bits above zero.
REQ-013 rot_result  input  DATA_WIDTH  rotator output.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_data  output  DATA_WIDTH  captured rotate result.
REQ-017 out_err  output  1  request used an unsupported op; qualified by out_valid.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-019 in_ready is 1 in IDLE, and in DONE when out_ready=1; 0 otherwise.
REQ-020 Accept = in_valid & in_ready; on accept, register in_a into rot_a, the effective right amount into rot_shift[7:0], and op legality; next state ISSUE.
REQ-021 ISSUE lasts exactly one cycle, rot_enable=1; rot_enable=0 in every other state.
REQ-022 rot_a and rot_shift hold stable from ISSUE until the next accept.
REQ-023 ISSUE -> WAIT with a 3-bit counter loaded to ROT_LATENCY; WAIT decrements each cycle; rot_result is captured into out_data on the edge where the counter equals 0, then state -> DONE.
REQ-024 Accept at the edge ending cycle 0 gives out_valid=1 in cycle 2+ROT_LATENCY; ROT_LATENCY=0 spends one cycle in WAIT.
REQ-025 DONE holds out_valid=1 and out_data/out_err stable until out_ready=1.
REQ-026 DONE with out_ready=1 and in_valid=0 -> IDLE; with in_valid=1 the new request is accepted the same edge -> ISSUE (back-to-back, no idle bubble).
REQ-027 in_shamt=0 passes in_a unchanged for both ops.
REQ-028 in_valid while busy (ISSUE/WAIT, or DONE without out_ready) is not accepted; upstream must hold its request.

Reset
REQ-029 rst_n=0 on a rising edge forces IDLE and counter 0, with out_valid=0, out_err=0, rot_enable=0, out_data=0, rot_a=0, rot_shift=0.
REQ-030 Reset mid-operation (ISSUE/WAIT/DONE) aborts the request; no result is ever presented for it.
REQ-031 First accept is possible on the first edge after rst_n returns high.

Configuration
REQ-032 Macro BMI_ROT_ISSUE_ROTL_EN:
- Defined: in_op=1 is legal; effective right amount = (256 - in_shamt) mod 256; out_err=0.
- Undefined: in_op=1 is illegal; effective amount = in_shamt (rotate right); out_err=1 with that result.
- in_op=0 is identical in both builds.

Verification (DATA_WIDTH=256, ROT_LATENCY=1, rotator model attached)
REQ-033 Reset then in_a=1, in_shamt=1, in_op=0, accepted cycle 0 -> rot_enable=1 in cycle 1; out_valid=1 in cycle 3; out_data has only bit 255 set; out_err=0.
REQ-034 With macro: in_a=1, in_shamt=1, in_op=1 -> rot_shift=255; out_data=2, out_err=0. Without macro -> out_data bit 255 set, out_err=1.
REQ-035 in_shamt=0 with in_a=0xA5 for both ops -> out_data=0xA5.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; release with in_valid=1 -> new request accepted that edge, next result 3 cycles later.
REQ-037 rst_n=0 asserted during WAIT -> next cycle IDLE, out_valid=0, rot_enable=0; no stale result appears afterward.

Source files
------------

// File: rtl/bmi_rot_issue_if.sv
// bmi_rot_issue_if: request/result handshake bundle for bmi_rot_issue.
//   Request side : in_valid, in_ready, in_op, in_a, in_shamt
//   Result side  : out_valid, out_ready, out_data, out_err
//   master modport : the upstream/downstream environment
//   slave modport  : the bmi_rot_issue block
interface bmi_rot_issue_if #(
  parameter int DATA_WIDTH = 256
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_op;
  logic [DATA_WIDTH-1:0] in_a;
  logic [7:0]            in_shamt;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;

  modport master (
    output in_valid, in_op, in_a, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_shamt, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/bmi_rot_issue.sv
// bmi_rot_issue: issues one rotate request at a time to an external
// fixed-latency right-rotator and presents the captured result.
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   bus        : bmi_rot_issue_if.slave request/result handshake
//   rot_enable : high for the single ISSUE cycle
//   rot_a      : operand held for the rotator
//   rot_shift  : right-rotate amount in [7:0], upper bits zero
//   rot_result : rotator output, captured into bus.out_data
// Build option: define BMI_ROT_ISSUE_ROTL_EN to make in_op=1 (rotate left)
// legal; otherwise in_op=1 rotates right and flags out_err.
module bmi_rot_issue #(
  parameter int DATA_WIDTH  = 256,
  parameter int ROT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bmi_rot_issue_if.slave        bus,
  output logic                  rot_enable,
  output logic [DATA_WIDTH-1:0] rot_a,
  output logic [DATA_WIDTH-1:0] rot_shift,
  input  logic [DATA_WIDTH-1:0] rot_result
);

`ifdef BMI_ROT_ISSUE_ROTL_EN
  localparam bit ROTL_EN = 1'b1;
`else
  localparam bit ROTL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic [7:0] shamt_q;
  logic       err_q;
  logic       accept;
  logic       capture;
  logic [7:0] eff_shamt;
  logic       op_illegal;

  // A left rotate by n is a right rotate by (256 - n) mod 256, which is the
  // 8-bit two's complement negation of n.
  always_comb begin
    op_illegal = bus.in_op & ~ROTL_EN;
    if (bus.in_op && ROTL_EN) begin
      eff_shamt = 8'd0 - bus.in_shamt;
    end else begin
      eff_shamt = bus.in_shamt;
    end
  end

  // WAIT always lasts at least one cycle, then one more per latency step
  // beyond the first; the capture fires when the decremented count would
  // reach zero, so ROT_LATENCY of 0 and 1 both give a single WAIT cycle.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    rot_enable    = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = ISSUE;
      end
      ISSUE: begin
        rot_enable = 1'b1;
        cnt_next   = 3'(ROT_LATENCY);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt <= 3'd1) begin
          capture    = 1'b1;
          cnt_next   = 3'd0;
          state_next = DONE;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
    accept = bus.in_valid & bus.in_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      rot_a        <= '0;
      shamt_q      <= 8'd0;
      err_q        <= 1'b0;
      bus.out_data <= '0;
      bus.out_err  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        rot_a   <= bus.in_a;
        shamt_q <= eff_shamt;
        err_q   <= op_illegal;
      end
      if (capture) begin
        bus.out_data <= rot_result;
        bus.out_err  <= err_q;
      end
    end
  end

  assign rot_shift = {{(DATA_WIDTH-8){1'b0}}, shamt_q};

endmodule

// File: tb/tb_bmi_rot_issue.sv
// tb_bmi_rot_issue: directed and randomized checks of bmi_rot_issue with a
// one-cycle right-rotator model attached. Expected results come from a
// bit-level rotate reference that follows the op/shift rules directly.
module tb_bmi_rot_issue;
  localparam int W = 256;

`ifdef BMI_ROT_ISSUE_ROTL_EN
  localparam bit ROTL = 1'b1;
`else
  localparam bit ROTL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rot_enable;
  logic [W-1:0] rot_a;
  logic [W-1:0] rot_shift;
  logic [W-1:0] rot_result;
  logic [2*W-1:0] rot_dbl;

  int vectors = 0;
  int miscompares = 0;

  bmi_rot_issue_if #(.DATA_WIDTH(W)) bus ();

  bmi_rot_issue #(.DATA_WIDTH(W), .ROT_LATENCY(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rot_enable (rot_enable),
    .rot_a      (rot_a),
    .rot_shift  (rot_shift),
    .rot_result (rot_result)
  );

  always #5 clk = ~clk;

  // Rotator with one edge of latency
  assign rot_dbl = {rot_a, rot_a} >> rot_shift[7:0];
  always @(posedge clk) rot_result <= rot_dbl[W-1:0];

  function automatic logic [W-1:0] refRotate(input logic op, input logic [W-1:0] a,
                                             input logic [7:0] sh);
    logic [W-1:0] r;
    int s;
    s = int'(sh);
    for (int i = 0; i < W; i++) begin
      if (op && ROTL) r[i] = a[(i - s + W) % W];
      else            r[i] = a[(i + s) % W];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] refShift(input logic op, input logic [7:0] sh);
    int s;
    s = (op && ROTL) ? (256 - int'(sh)) % 256 : int'(sh);
    return W'(s);
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] r;
    for (int k = 0; k < W/32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic op, input logic [W-1:0] a,
                               input logic [7:0] sh);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_shamt = sh;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts just after a rising edge with the DUT ready to accept; returns at
  // the falling edge of the cycle where the result is first presented.
  task automatic runTxn(input logic op, input logic [W-1:0] a, input logic [7:0] sh);
    logic [W-1:0] exp_data;
    exp_data = refRotate(op, a, sh);
    applyStimulus(1'b1, op, a, sh);
    @(negedge clk);
    checkOutput("in_ready_c0", W'(bus.in_ready), W'(1'b1));
    @(posedge clk); #1;
    applyStimulus(1'b0, $urandom_range(0, 1) != 0, randWide(), 8'($urandom));
    @(negedge clk);
    checkOutput("rot_enable_c1", W'(rot_enable), W'(1'b1));
    checkOutput("rot_a_c1", rot_a, a);
    checkOutput("rot_shift_c1", rot_shift, refShift(op, sh));
    checkOutput("out_valid_c1", W'(bus.out_valid), W'(1'b0));
    @(negedge clk);
    checkOutput("rot_enable_c2", W'(rot_enable), W'(1'b0));
    checkOutput("out_valid_c2", W'(bus.out_valid), W'(1'b0));
    @(negedge clk);
    checkOutput("out_valid_c3", W'(bus.out_valid), W'(1'b1));
    checkOutput("out_data_c3", bus.out_data, exp_data);
    checkOutput("out_err_c3", W'(bus.out_err), W'(op & ~ROTL));
  endtask

  initial begin
    logic [W-1:0] a_hold;
    logic [W-1:0] exp_hold;
    logic [W-1:0] b_a;
    logic [7:0]   sh;
    logic         op;

    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", W'(bus.out_valid), W'(1'b0));
    checkOutput("rst_out_err", W'(bus.out_err), W'(1'b0));
    checkOutput("rst_rot_enable", W'(rot_enable), W'(1'b0));
    checkOutput("rst_out_data", bus.out_data, '0);
    checkOutput("rst_rot_a", rot_a, '0);
    checkOutput("rst_rot_shift", rot_shift, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] basic rotate right by one");
    runTxn(1'b0, W'(1), 8'd1);
    checkOutput("ror1_bit255", bus.out_data, {1'b1, {(W-1){1'b0}}});
    @(posedge clk); #1;

    $display("[TB] op=1 by one");
    runTxn(1'b1, W'(1), 8'd1);
    @(posedge clk); #1;

    $display("[TB] zero shift both ops");
    runTxn(1'b0, W'(8'hA5), 8'd0);
    checkOutput("sh0_op0", bus.out_data, W'(8'hA5));
    @(posedge clk); #1;
    runTxn(1'b1, W'(8'hA5), 8'd0);
    checkOutput("sh0_op1", bus.out_data, W'(8'hA5));
    @(posedge clk); #1;

    $display("[TB] randomized requests");
    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 1) != 0;
      sh = (i == 0) ? 8'd255 : (i == 1) ? 8'd128 : 8'($urandom);
      runTxn(op, randWide(), sh);
      @(posedge clk); #1;
    end

    $display("[TB] backpressure then back-to-back");
    a_hold = randWide();
    exp_hold = refRotate(1'b0, a_hold, 8'd37);
    b_a = randWide();
    bus.out_ready = 1'b0;
    runTxn(1'b0, a_hold, 8'd37);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, b_a, 8'd200);
      @(negedge clk);
      checkOutput("hold_out_valid", W'(bus.out_valid), W'(1'b1));
      checkOutput("hold_out_data", bus.out_data, exp_hold);
      checkOutput("hold_in_ready", W'(bus.in_ready), W'(1'b0));
      checkOutput("hold_rot_enable", W'(rot_enable), W'(1'b0));
      checkOutput("hold_rot_a", rot_a, a_hold);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    runTxn(1'b0, b_a, 8'd200);
    @(posedge clk); #1;

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 1'b0, randWide(), 8'd9);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, '0, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", W'(bus.out_valid), W'(1'b0));
    checkOutput("mid_rst_rot_enable", W'(rot_enable), W'(1'b0));
    checkOutput("mid_rst_in_ready", W'(bus.in_ready), W'(1'b1));
    checkOutput("mid_rst_out_data", bus.out_data, '0);
    checkOutput("mid_rst_rot_a", rot_a, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("no_stale_valid", W'(bus.out_valid), W'(1'b0));
    end
    @(posedge clk); #1;
    runTxn(1'b1, randWide(), 8'd3);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
